// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (double-dabble): one operand bit per cycle,
// with a single add-3 corrector per digit, a start/done handshake and sticky overflow.

module bin2bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic                overflow
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t         state, state_nx;
   logic [WIDTH-1:0] opnd;
   logic [BW-1:0]  scratch;
   logic [BW-1:0]  adj;
   logic           sticky;
   logic [CW-1:0]  cnt;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bin2bcd_add3 u_add3 (.d(scratch[4*g +: 4]), .q(adj[4*g +: 4]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_SHIFT;
         ST_SHIFT: if (cnt == CW'(1)) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Status flags are registered so no input reaches an output combinationally;
   // done rises on the transfer edge, together with bcd/overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nx == ST_SHIFT);
         done <= (state == ST_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opnd     <= '0;
         scratch  <= '0;
         sticky   <= 1'b0;
         cnt      <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               opnd    <= bin;
               scratch <= '0;
               sticky  <= 1'b0;
               cnt     <= CW'(WIDTH);
            end
            ST_SHIFT: begin
               // The bit leaving the top digit would carry into a digit we don't keep.
               scratch <= {adj[BW-2:0], opnd[WIDTH-1]};
               opnd    <= opnd << 1;
               sticky  <= sticky | adj[BW-1];
               cnt     <= cnt - CW'(1);
            end
            ST_DONE: begin
               bcd      <= scratch;
               overflow <= sticky;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq across several WIDTH/DIGITS configurations.

module tb_bin2bcd_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // W=8 D=3
   logic        start8 = 0;
   logic [7:0]  bin8 = 0;
   logic        busy8, done8, ovf8;
   logic [11:0] bcd8;
   // W=4 D=2
   logic        start4 = 0;
   logic [3:0]  bin4 = 0;
   logic        busy4, done4, ovf4;
   logic [7:0]  bcd4;
   // W=8 D=2
   logic        start82 = 0;
   logic [7:0]  bin82 = 0;
   logic        busy82, done82, ovf82;
   logic [7:0]  bcd82;
   // W=16 D=5
   logic        start16 = 0;
   logic [15:0] bin16 = 0;
   logic        busy16, done16, ovf16;
   logic [19:0] bcd16;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u8_3 (.clk(clk), .rst_n(rst_n), .start(start8),
      .bin(bin8), .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8));
   bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) u4_2 (.clk(clk), .rst_n(rst_n), .start(start4),
      .bin(bin4), .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4));
   bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u8_2 (.clk(clk), .rst_n(rst_n), .start(start82),
      .bin(bin82), .busy(busy82), .done(done82), .bcd(bcd82), .overflow(ovf82));
   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u16_5 (.clk(clk), .rst_n(rst_n), .start(start16),
      .bin(bin16), .busy(busy16), .done(done16), .bcd(bcd16), .overflow(ovf16));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({busy8, done8, ovf8, bcd8} !== 15'd0) begin
         bad++;
         $display("FAIL reset_w8d3 got busy=%b done=%b ovf=%b bcd=%h want all 0", busy8, done8, ovf8, bcd8);
      end
      total++;
      if ({busy16, done16, ovf16, bcd16, busy4, done4, ovf4, bcd4} !== 34'd0) begin
         bad++;
         $display("FAIL reset_others got bcd16=%h bcd4=%h flags=%b%b%b%b%b%b want all 0",
                  bcd16, bcd4, busy16, done16, ovf16, busy4, done4, ovf4);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int nbusy = 0;
      int ndone = 0;
      start8 = 1'b1;
      bin8 = 8'd255;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (busy8) nbusy++;
         if (done8) ndone++;
         total++;
         if (busy8 !== (i <= 7)) begin
            bad++;
            $display("FAIL basic_busy cyc=%0d got %b want %b", i, busy8, (i <= 7));
         end
         total++;
         if (done8 !== (i == 9)) begin
            bad++;
            $display("FAIL basic_done cyc=%0d got %b want %b", i, done8, (i == 9));
         end
         if (i == 9) begin
            total++;
            if (bcd8 !== 12'h255 || ovf8 !== 1'b0) begin
               bad++;
               $display("FAIL basic_result got bcd=%h ovf=%b want 255/0", bcd8, ovf8);
            end
         end
         tick();
      end
      total++;
      if (nbusy != 8 || ndone != 1) begin
         bad++;
         $display("FAIL basic_counts got busy=%0d done=%0d want 8/1", nbusy, ndone);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] exp;
      for (int v = 0; v < 16; v++) begin
         int n = 0;
         exp = (v < 10) ? 8'(v) : 8'(8'h10 + (v - 10));
         start4 = 1'b1;
         bin4 = 4'(v);
         tick();
         start4 = 1'b0;
         while (!done4 && n < 20) begin
            tick();
            n++;
         end
         total++;
         if (!done4 || n != 5) begin
            bad++;
            $display("FAIL sweep_latency v=%0d got n=%0d done=%b want 5/1", v, n, done4);
         end
         total++;
         if (bcd4 !== exp || ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL sweep_value v=%0d got bcd=%h ovf=%b want %h/0", v, bcd4, ovf4, exp);
         end
         tick();
      end
   endtask

   task automatic test_overflow();
      logic [7:0] vin [3] = '{8'd99, 8'd200, 8'd123};
      logic [7:0] vexp[3] = '{8'h99, 8'h00, 8'h23};
      logic       vovf[3] = '{1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) begin
         int n = 0;
         start82 = 1'b1;
         bin82 = vin[k];
         tick();
         start82 = 1'b0;
         while (!done82 && n < 30) begin
            tick();
            n++;
         end
         total++;
         if (!done82 || bcd82 !== vexp[k] || ovf82 !== vovf[k]) begin
            bad++;
            $display("FAIL overflow_d2 in=%0d got done=%b bcd=%h ovf=%b want 1/%h/%b",
                     vin[k], done82, bcd82, ovf82, vexp[k], vovf[k]);
         end
         tick();
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      int n = 0;
      start8 = 1'b1;
      bin8 = 8'd42;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (done8) ndone++;
         total++;
         if (busy8 !== (i <= 7) || done8 !== (i == 9)) begin
            bad++;
            $display("FAIL ignore_flags cyc=%0d got busy=%b done=%b want %b/%b",
                     i, busy8, done8, (i <= 7), (i == 9));
         end
         // i=3 is mid-SHIFT, i=8 is the DONE-state cycle
         start8 = (i == 3 || i == 8);
         bin8 = (i == 3 || i == 8) ? 8'd200 : 8'd42;
         tick();
         start8 = 1'b0;
      end
      total++;
      if (ndone != 1 || bcd8 !== 12'h042 || ovf8 !== 1'b0) begin
         bad++;
         $display("FAIL ignore_result got ndone=%0d bcd=%h ovf=%b want 1/042/0", ndone, bcd8, ovf8);
      end
      start8 = 1'b1;
      bin8 = 8'd7;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      tick();
      total++;
      if (bcd8 !== 12'h042) begin
         bad++;
         $display("FAIL hold_midconv got bcd=%h want 042", bcd8);
      end
      while (!done8 && n < 30) begin
         tick();
         n++;
      end
      total++;
      if (!done8 || bcd8 !== 12'h007) begin
         bad++;
         $display("FAIL hold_next got done=%b bcd=%h want 1/007", done8, bcd8);
      end
      tick();
   endtask

   task automatic test_wide_reset();
      int n = 0;
      start16 = 1'b1;
      bin16 = 16'd65535;
      tick();
      start16 = 1'b0;
      while (!done16 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (!done16 || n != 17 || bcd16 !== 20'h65535 || ovf16 !== 1'b0) begin
         bad++;
         $display("FAIL wide_65535 got done=%b n=%0d bcd=%h ovf=%b want 1/17/65535/0",
                  done16, n, bcd16, ovf16);
      end
      tick();
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy16, done16, ovf16, bcd16} !== 23'd0) begin
         bad++;
         $display("FAIL async_reset got busy=%b done=%b ovf=%b bcd=%h want all 0",
                  busy16, done16, ovf16, bcd16);
      end
      #3 rst_n = 1'b1;
      tick();
      start16 = 1'b1;
      bin16 = 16'd0;
      tick();
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (!done16 || n != 17 || bcd16 !== 20'h0 || ovf16 !== 1'b0) begin
         bad++;
         $display("FAIL wide_zero got done=%b n=%0d bcd=%h ovf=%b want 1/17/0/0",
                  done16, n, bcd16, ovf16);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  vin [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
      logic [11:0] vexp[6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
      int n;
      start8 = 1'b1;
      bin8 = vin[0];
      tick();
      start8 = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         while (!done8 && n < 30) begin
            tick();
            n++;
         end
         total++;
         if (!done8 || n != ((k == 0) ? 9 : 10) || bcd8 !== vexp[k] || ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b k=%0d got done=%b gap=%0d bcd=%h ovf=%b want 1/%0d/%h/0",
                     k, done8, n, bcd8, ovf8, (k == 0) ? 9 : 10, vexp[k]);
         end
         if (k < 5) begin
            start8 = 1'b1;
            bin8 = vin[k+1];
         end
         tick();
         start8 = 1'b0;
         n = 1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_overflow();
      test_ignore_start();
      test_wide_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
